// File: rtl/tl_sram_device_pkg.sv
// rtl/tl_sram_device_pkg.sv - TileLink opcode enums and burst beat-count helper
package tl_sram_device_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    ArithmeticData = 3'h2,
    LogicalData    = 3'h3,
    Get            = 3'h4,
    Intent         = 3'h5,
    AcquireBlock   = 3'h6,
    AcquirePerm    = 3'h7
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1,
    HintAck       = 3'h2,
    Grant         = 3'h4,
    GrantData     = 3'h5,
    ReleaseAck    = 3'h6
  } tl_d_op_e;

  // Transfers narrower than one beat still occupy a full beat.
  function automatic int unsigned beat_count(input int unsigned size, input int unsigned data_width);
    int unsigned off;
    off = $clog2(data_width / 8);
    if (size <= off) return 1;
    return 32'd1 << (size - off);
  endfunction

endpackage

// File: rtl/tl_sram_device_if.sv
// rtl/tl_sram_device_if.sv - TileLink A/D channel bundle between host and SRAM device
interface tl_sram_device_if
  import tl_sram_device_pkg::*;
#(
  parameter int AddrWidth   = 56,
  parameter int DataWidth   = 64,
  parameter int SourceWidth = 1,
  parameter int SinkWidth   = 1,
  parameter int SizeWidth   = 3
);
  localparam int MaskWidth = DataWidth / 8;

  logic                   a_valid;
  logic                   a_ready;
  tl_a_op_e               a_opcode;
  logic [2:0]             a_param;
  logic [SizeWidth-1:0]   a_size;
  logic [SourceWidth-1:0] a_source;
  logic [AddrWidth-1:0]   a_address;
  logic [MaskWidth-1:0]   a_mask;
  logic                   a_corrupt;
  logic [DataWidth-1:0]   a_data;

  logic                   d_valid;
  logic                   d_ready;
  tl_d_op_e               d_opcode;
  logic [1:0]             d_param;
  logic [SizeWidth-1:0]   d_size;
  logic [SourceWidth-1:0] d_source;
  logic [SinkWidth-1:0]   d_sink;
  logic                   d_denied;
  logic                   d_corrupt;
  logic [DataWidth-1:0]   d_data;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_corrupt, a_data,
    input  a_ready,
    input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt, d_data,
    output d_ready
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_corrupt, a_data,
    output a_ready,
    output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt, d_data,
    input  d_ready
  );

endinterface

// File: rtl/tl_sram_device.sv
// rtl/tl_sram_device.sv - TileLink UL/UH device endpoint serving A requests from a 1-port SRAM
module tl_sram_device
  import tl_sram_device_pkg::*;
#(
  parameter int AddrWidth    = 56,
  parameter int DataWidth    = 64,
  parameter int SourceWidth  = 1,
  parameter int SinkWidth    = 1,
  parameter int SizeWidth    = 3,
  parameter int MemAddrWidth = 10,
  localparam int MaskWidth   = DataWidth / 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  tl_sram_device_if.slave         tl,
  output logic                    b_valid,
  output logic                    c_ready,
  output logic                    e_ready,
  output logic                    sram_req_o,
  output logic                    sram_we_o,
  output logic [MemAddrWidth-1:0] sram_addr_o,
  output logic [MaskWidth-1:0]    sram_wmask_o,
  output logic [DataWidth-1:0]    sram_wdata_o,
  input  logic [DataWidth-1:0]    sram_rdata_i
);

  localparam int OffW   = $clog2(MaskWidth);
  localparam int MaxLog = (2 ** SizeWidth - 1) - OffW;
  localparam int CntW   = (MaxLog < 1) ? 1 : MaxLog;

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_DRAIN, S_RD_REQ, S_RD_RESP, S_ACK} state_e;

  state_e                  state_q, state_d;
  tl_a_op_e                op_q;
  logic [SizeWidth-1:0]    size_q;
  logic [SourceWidth-1:0]  source_q;
  logic [MemAddrWidth-1:0] base_q;
  logic [CntW-1:0]         idx_q, last_q, last_in;
  logic                    denied_q, rd_first_q;
  logic [DataWidth-1:0]    rdata_q;
  logic [MemAddrWidth-1:0] a_word;
  logic                    a_is_put, a_is_get, a_has_data;
  logic                    unused_bits;

  assign a_word     = tl.a_address[OffW +: MemAddrWidth];
  assign last_in    = CntW'(beat_count(32'(tl.a_size), DataWidth) - 32'd1);
  assign a_is_put   = (tl.a_opcode == PutFullData) || (tl.a_opcode == PutPartialData);
  assign a_is_get   = (tl.a_opcode == Get);
  assign a_has_data = (tl.a_opcode == ArithmeticData) || (tl.a_opcode == LogicalData);

  assign b_valid     = 1'b0;
  assign c_ready     = 1'b1;
  assign e_ready     = 1'b1;
  assign tl.d_param  = '0;
  assign tl.d_sink   = '0;
  assign tl.d_size   = size_q;
  assign tl.d_source = source_q;
  assign tl.d_denied = (state_q == S_ACK) && denied_q;
  assign tl.d_corrupt = (state_q == S_RD_RESP) && denied_q;
  // The SRAM word is only valid in the first response cycle; afterwards the held copy is used.
  assign tl.d_data   = rd_first_q ? sram_rdata_i : rdata_q;
  assign unused_bits = ^{tl.a_param, tl.a_address, op_q};

  always_comb begin
    state_d      = state_q;
    tl.a_ready   = 1'b0;
    tl.d_valid   = 1'b0;
    tl.d_opcode  = AccessAck;
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = base_q + MemAddrWidth'(idx_q);
    sram_wmask_o = '0;
    sram_wdata_o = tl.a_data;
    unique case (state_q)
      S_IDLE: begin
        tl.a_ready  = 1'b1;
        sram_addr_o = a_word;
        if (tl.a_valid) begin
          if (a_is_put) begin
            sram_req_o   = 1'b1;
            sram_we_o    = 1'b1;
            sram_wmask_o = tl.a_corrupt ? '0 : tl.a_mask;
            state_d      = (last_in == '0) ? S_ACK : S_WRITE;
          end else if (a_is_get) begin
            state_d = S_RD_REQ;
          end else if (a_has_data && (last_in != '0)) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_ACK;
          end
        end
      end
      S_WRITE: begin
        tl.a_ready = 1'b1;
        if (tl.a_valid) begin
          sram_req_o   = 1'b1;
          sram_we_o    = 1'b1;
          sram_wmask_o = tl.a_corrupt ? '0 : tl.a_mask;
          if (idx_q == last_q) state_d = S_ACK;
        end
      end
      S_DRAIN: begin
        tl.a_ready = 1'b1;
        if (tl.a_valid && (idx_q == last_q)) state_d = S_ACK;
      end
      S_RD_REQ: begin
        sram_req_o = 1'b1;
        state_d    = S_RD_RESP;
      end
      S_RD_RESP: begin
        tl.d_valid  = 1'b1;
        tl.d_opcode = AccessAckData;
        if (tl.d_ready) state_d = (idx_q == last_q) ? S_IDLE : S_RD_REQ;
      end
      S_ACK: begin
        tl.d_valid = 1'b1;
        if (tl.d_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Reset must not leak a write or an A acceptance in the cycle it is asserted.
    if (rst_i) begin
      tl.a_ready = 1'b0;
      sram_req_o = 1'b0;
      sram_we_o  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      op_q       <= PutFullData;
      size_q     <= '0;
      source_q   <= '0;
      base_q     <= '0;
      idx_q      <= '0;
      last_q     <= '0;
      denied_q   <= 1'b0;
      rd_first_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      rd_first_q <= (state_q == S_RD_REQ);
      if (rd_first_q) rdata_q <= sram_rdata_i;
      if ((state_q == S_IDLE) && tl.a_valid) begin
        op_q     <= tl.a_opcode;
        size_q   <= tl.a_size;
        source_q <= tl.a_source;
        base_q   <= a_word;
        last_q   <= last_in;
        idx_q    <= a_is_get ? CntW'(0) : CntW'(1);
        denied_q <= !(a_is_put || a_is_get);
      end else if (((state_q == S_WRITE) || (state_q == S_DRAIN)) && tl.a_valid) begin
        idx_q <= idx_q + CntW'(1);
      end else if ((state_q == S_RD_RESP) && tl.d_ready && (idx_q != last_q)) begin
        idx_q <= idx_q + CntW'(1);
      end
    end
  end

endmodule
